// File: rtl/gpio_lane_writer.sv
// GPIO output register bank: each pushbutton press commits a write/set/clear/toggle
// of switch data into one lane; the whole register can optionally rotate by lanes.
module gpio_lane_writer #(
    parameter int GPIO_W      = 32,
    parameter int LANE_W      = 8,
    parameter int RATE_DIV    = 25_000_000,
    parameter int SYNC_STAGES = 2,
    localparam int NUM_LANES  = GPIO_W / LANE_W,
    localparam int SEL_W      = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic [LANE_W-1:0] DATA,
    input  logic [SEL_W-1:0]  LANE_SEL,
    input  logic [1:0]        OP,
    input  logic              COMMIT_N,
    input  logic              ROTATE_EN,
    input  logic              ROTATE_DIR,
    output logic [GPIO_W-1:0] GPIO,
    output logic              COMMIT_ACK,
    output logic              TICK
);

    localparam int CNT_W = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RATE_DIV - 1);

    if (GPIO_W % LANE_W != 0) begin : g_width_check
        $error("gpio_lane_writer: GPIO_W must be a multiple of LANE_W");
    end
    if (RATE_DIV < 1) begin : g_rate_check
        $error("gpio_lane_writer: RATE_DIV must be at least 1");
    end
    if (SYNC_STAGES < 2) begin : g_sync_check
        $error("gpio_lane_writer: SYNC_STAGES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   key_prev;
    logic                   commit_p;
    logic [CNT_W-1:0]       count;
    logic                   tick_p;
    logic                   lane_hit;
    logic [GPIO_W-1:0]      committed;
    logic [GPIO_W-1:0]      rotated;

    function automatic logic [LANE_W-1:0] lane_op(input logic [1:0]        op,
                                                  input logic [LANE_W-1:0] old,
                                                  input logic [LANE_W-1:0] d);
        case (op)
            2'b00:   return d;
            2'b01:   return old | d;
            2'b10:   return old & ~d;
            default: return old ^ d;
        endcase
    endfunction

    // Chain and edge flop reset to "pressed" so a key held through reset is ignored
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            sync_chain <= '0;
            key_prev   <= 1'b0;
            commit_p   <= 1'b0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], COMMIT_N};
            key_prev   <= sync_chain[SYNC_STAGES-1];
            commit_p   <= key_prev & ~sync_chain[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET || !ROTATE_EN) begin
            count <= '0;
        end else if (count == CNT_MAX) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick_p = ROTATE_EN && (count == CNT_MAX);

    // Out-of-range selects never match a lane, so they leave GPIO untouched
    always_comb begin
        committed = GPIO;
        lane_hit  = 1'b0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (LANE_SEL == SEL_W'(k)) begin
                lane_hit = 1'b1;
                committed[k*LANE_W +: LANE_W] = lane_op(OP, GPIO[k*LANE_W +: LANE_W], DATA);
            end
        end
    end

    always_comb begin
        rotated = GPIO;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (ROTATE_DIR) begin
                rotated[k*LANE_W +: LANE_W] = GPIO[((k + 1) % NUM_LANES)*LANE_W +: LANE_W];
            end else begin
                rotated[((k + 1) % NUM_LANES)*LANE_W +: LANE_W] = GPIO[k*LANE_W +: LANE_W];
            end
        end
    end

    // A commit wins over a coincident rotate step; that step is simply lost
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            GPIO       <= '0;
            COMMIT_ACK <= 1'b0;
            TICK       <= 1'b0;
        end else if (commit_p && lane_hit) begin
            GPIO       <= committed;
            COMMIT_ACK <= 1'b1;
            TICK       <= 1'b0;
        end else if (tick_p) begin
            GPIO       <= rotated;
            COMMIT_ACK <= 1'b0;
            TICK       <= 1'b1;
        end else begin
            COMMIT_ACK <= 1'b0;
            TICK       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gpio_lane_writer.sv
// Bench for gpio_lane_writer: directed scenarios plus random presses/rotation,
// all compared every cycle against a behavioural model of the register bank.
module tb_gpio_lane_writer;

    localparam int GPIO_W      = 32;
    localparam int LANE_W      = 8;
    localparam int RATE_DIV    = 4;
    localparam int SYNC_STAGES = 2;

    logic        CLOCK_50 = 1'b0;
    logic        RESET;
    logic [7:0]  DATA;
    logic [1:0]  LANE_SEL;
    logic [1:0]  OP;
    logic        COMMIT_N;
    logic        ROTATE_EN;
    logic        ROTATE_DIR;
    logic [31:0] GPIO;
    logic        COMMIT_ACK;
    logic        TICK;

    int check_count = 0;
    int pass_count  = 0;
    int ack_count   = 0;
    int tick_count  = 0;
    int lat;
    int cyc;

    logic [31:0] ref_gpio;
    logic        ref_ack;
    logic        ref_tick;
    logic        key_hist[$];
    int          en_run;
    int          hn;
    bit          m_press;
    bit          m_tick;

    logic [31:0] seq_l[4] = '{32'h0000_1100, 32'h0011_0000, 32'h1100_0000, 32'h0000_0011};
    logic [31:0] seq_r[4] = '{32'h1100_0000, 32'h0011_0000, 32'h0000_1100, 32'h0000_0011};

    gpio_lane_writer #(
        .GPIO_W(GPIO_W), .LANE_W(LANE_W), .RATE_DIV(RATE_DIV), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .CLOCK_50(CLOCK_50), .RESET(RESET), .DATA(DATA), .LANE_SEL(LANE_SEL), .OP(OP),
        .COMMIT_N(COMMIT_N), .ROTATE_EN(ROTATE_EN), .ROTATE_DIR(ROTATE_DIR),
        .GPIO(GPIO), .COMMIT_ACK(COMMIT_ACK), .TICK(TICK)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: observed %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [7:0] model_op(input logic [1:0] op, input logic [7:0] old, input logic [7:0] d);
        case (op)
            2'b00:   return d;
            2'b01:   return old | d;
            2'b10:   return old & ~d;
            default: return old ^ d;
        endcase
    endfunction

    // Model: a press is a 1->0 key sample; it lands SYNC_STAGES+2 edges after the first low sample
    always @(posedge CLOCK_50) begin
        if (RESET) begin
            ref_gpio = '0;
            ref_ack  = 1'b0;
            ref_tick = 1'b0;
            en_run   = 0;
            key_hist.delete();
            for (int i = 0; i < SYNC_STAGES + 2; i++) key_hist.push_back(1'b0);
        end else begin
            key_hist.push_back(COMMIT_N);
            hn = key_hist.size();
            m_press = (key_hist[hn-1-(SYNC_STAGES+1)] == 1'b0) && (key_hist[hn-1-(SYNC_STAGES+2)] == 1'b1);
            void'(key_hist.pop_front());
            m_tick = ROTATE_EN && ((en_run % RATE_DIV) == RATE_DIV - 1);
            en_run = ROTATE_EN ? (en_run + 1) % RATE_DIV : 0;
            ref_ack  = 1'b0;
            ref_tick = 1'b0;
            if (m_press) begin
                ref_gpio[LANE_SEL*LANE_W +: LANE_W] = model_op(OP, ref_gpio[LANE_SEL*LANE_W +: LANE_W], DATA);
                ref_ack = 1'b1;
            end else if (m_tick) begin
                if (ROTATE_DIR)
                    ref_gpio = (ref_gpio >> LANE_W) | (ref_gpio << (GPIO_W - LANE_W));
                else
                    ref_gpio = (ref_gpio << LANE_W) | (ref_gpio >> (GPIO_W - LANE_W));
                ref_tick = 1'b1;
            end
        end
    end

    always @(negedge CLOCK_50) begin
        checkOutput("model_gpio", GPIO, ref_gpio);
        checkOutput("model_ack", {31'b0, COMMIT_ACK}, {31'b0, ref_ack});
        checkOutput("model_tick", {31'b0, TICK}, {31'b0, ref_tick});
        if (COMMIT_ACK === 1'b1) ack_count++;
        if (TICK === 1'b1) tick_count++;
    end

    task automatic applyStimulus(input logic [7:0] d, input logic [1:0] s, input logic [1:0] o, input int hold);
        @(negedge CLOCK_50);
        DATA     = d;
        LANE_SEL = s;
        OP       = o;
        COMMIT_N = 1'b0;
        repeat (hold) @(negedge CLOCK_50);
        COMMIT_N = 1'b1;
        repeat (SYNC_STAGES + 3) @(negedge CLOCK_50);
    endtask

    task automatic waitTick(output int cycles);
        cycles = 0;
        do begin
            @(negedge CLOCK_50);
            cycles++;
        end while (TICK !== 1'b1 && cycles < 20);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RESET = 1'b1; COMMIT_N = 1'b1; ROTATE_EN = 1'b0; ROTATE_DIR = 1'b0;
        DATA = '0; LANE_SEL = '0; OP = '0;
        @(negedge CLOCK_50);
        checkOutput("rst_gpio", GPIO, 32'h0);
        checkOutput("rst_ack", {31'b0, COMMIT_ACK}, 32'h0);
        checkOutput("rst_tick", {31'b0, TICK}, 32'h0);
        RESET = 1'b0;
        repeat (5) @(negedge CLOCK_50);

        DATA = 8'hA5; LANE_SEL = 2'd2; OP = 2'b00; COMMIT_N = 1'b0;
        lat = 0;
        while (COMMIT_ACK !== 1'b1 && lat < 10) begin
            @(posedge CLOCK_50);
            lat++;
            #1;
        end
        checkOutput("t1_latency", lat, SYNC_STAGES + 2);
        checkOutput("t1_gpio", GPIO, 32'h00A5_0000);
        @(posedge CLOCK_50); #1;
        checkOutput("t1_ack_pulse", {31'b0, COMMIT_ACK}, 32'h0);
        @(negedge CLOCK_50);
        COMMIT_N = 1'b1;
        repeat (5) @(negedge CLOCK_50);

        applyStimulus(8'h0F, 2'd2, 2'b01, 2);
        checkOutput("t2_set", GPIO, 32'h00AF_0000);
        applyStimulus(8'hA0, 2'd2, 2'b10, 2);
        checkOutput("t2_clear", GPIO, 32'h000F_0000);
        applyStimulus(8'hFF, 2'd2, 2'b11, 2);
        checkOutput("t2_toggle", GPIO, 32'h00F0_0000);

        ack_count = 0;
        applyStimulus(8'h5A, 2'd0, 2'b00, 20);
        checkOutput("t3_hold_acks", ack_count, 1);
        checkOutput("t3_hold_gpio", GPIO, 32'h00F0_005A);

        @(negedge CLOCK_50);
        COMMIT_N = 1'b0; RESET = 1'b1;
        @(negedge CLOCK_50);
        RESET = 1'b0; ack_count = 0;
        repeat (10) @(negedge CLOCK_50);
        checkOutput("t3_held_rst_acks", ack_count, 0);
        checkOutput("t3_held_rst_gpio", GPIO, 32'h0);
        COMMIT_N = 1'b1;
        repeat (5) @(negedge CLOCK_50);
        applyStimulus(8'h11, 2'd0, 2'b00, 2);
        checkOutput("t3_repress_acks", ack_count, 1);
        checkOutput("t3_repress_gpio", GPIO, 32'h0000_0011);

        @(negedge CLOCK_50);
        ROTATE_EN = 1'b1; ROTATE_DIR = 1'b0;
        for (int i = 0; i < 4; i++) begin
            waitTick(cyc);
            checkOutput("t4_left_interval", cyc, RATE_DIV);
            checkOutput("t4_left_gpio", GPIO, seq_l[i]);
        end
        ROTATE_DIR = 1'b1;
        for (int i = 0; i < 4; i++) begin
            waitTick(cyc);
            checkOutput("t4_right_interval", cyc, RATE_DIV);
            checkOutput("t4_right_gpio", GPIO, seq_r[i]);
        end

        DATA = 8'h3C; LANE_SEL = 2'd1; OP = 2'b00; COMMIT_N = 1'b0;
        repeat (SYNC_STAGES + 2) @(negedge CLOCK_50);
        checkOutput("t5_conflict_gpio", GPIO, 32'h0000_3C11);
        checkOutput("t5_conflict_ack", {31'b0, COMMIT_ACK}, 32'h1);
        checkOutput("t5_conflict_tick", {31'b0, TICK}, 32'h0);
        COMMIT_N = 1'b1;
        waitTick(cyc);
        checkOutput("t5_next_tick", cyc, RATE_DIV);
        checkOutput("t5_next_gpio", GPIO, 32'h1100_003C);
        repeat (3) @(negedge CLOCK_50);

        DATA = 8'h77; LANE_SEL = 2'd3; OP = 2'b01; COMMIT_N = 1'b0;
        @(negedge CLOCK_50);
        RESET = 1'b1; ROTATE_EN = 1'b0;
        @(negedge CLOCK_50);
        RESET = 1'b0;
        checkOutput("t6_rst_gpio", GPIO, 32'h0);
        ack_count = 0; tick_count = 0;
        repeat (10) @(negedge CLOCK_50);
        checkOutput("t6_no_ack", ack_count, 0);
        checkOutput("t6_no_tick", tick_count, 0);
        COMMIT_N = 1'b1;
        repeat (5) @(negedge CLOCK_50);

        for (int n = 0; n < 80; n++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r == 0) begin
                @(negedge CLOCK_50);
                RESET = 1'b1;
                @(negedge CLOCK_50);
                RESET = 1'b0;
            end else if (r < 5) begin
                ROTATE_EN  = 1'($urandom_range(0, 1));
                ROTATE_DIR = 1'($urandom_range(0, 1));
                repeat ($urandom_range(1, 12)) @(negedge CLOCK_50);
            end else begin
                applyStimulus(8'($urandom), 2'($urandom), 2'($urandom), int'($urandom_range(1, 6)));
            end
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
